// File: rtl/syn_debug_console_if.sv
// Debug/step bus between the board console (master) and the CPU core (slave).
// Address width follows `DM_ADDR_BIT (defaults to 10 when not set by the core build).
`ifndef DM_ADDR_BIT
`define DM_ADDR_BIT 10
`endif

interface syn_debug_console_if;
  logic                    cpu_en;
  logic [4:0]              regfile_req_dbg;
  logic [`DM_ADDR_BIT-1:0] datamem_addr_dbg;
  logic [31:0]             pc_dbg;
  logic [31:0]             regfile_data_dbg;
  logic [31:0]             datamem_data_dbg;
  logic [31:0]             display;
  logic                    halted;
  logic                    jumped;
  logic                    branched;
  logic                    bubble;

  modport master (
    output cpu_en, regfile_req_dbg, datamem_addr_dbg,
    input  pc_dbg, regfile_data_dbg, datamem_data_dbg, display,
    input  halted, jumped, branched, bubble
  );

  modport slave (
    input  cpu_en, regfile_req_dbg, datamem_addr_dbg,
    output pc_dbg, regfile_data_dbg, datamem_data_dbg, display,
    output halted, jumped, branched, bubble
  );
endinterface

// File: rtl/syn_debug_console.sv
// Board-side debug console: run/step sequencing of the core, debug address capture,
// run statistics (only when DBG_STATS_EN is defined) and an 8-digit 7-segment scanner.
//
// state     | meaning
// ST_PAUSED | core stopped, waiting for run switch or a step edge
// ST_STEP   | single enabled core cycle
// ST_RUN    | free run, cpu_en once every RunDiv cycles
// ST_HALTED | core reported halt; only reset leaves this state
`ifndef DM_ADDR_BIT
`define DM_ADDR_BIT 10
`endif

module syn_debug_console #(
  parameter int unsigned RunDiv  = 32'd1,
  parameter int unsigned ScanDiv = 32'd50000,
  parameter int unsigned SyncLen = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_run_sw,
  input  logic                    i_step_btn,
  input  logic [`DM_ADDR_BIT-1:0] i_addr_sw,
  input  logic [2:0]              i_view_sel,
  output logic [7:0]              o_seg_sel,
  output logic [7:0]              o_seg_out,
  syn_debug_console_if.master     dbg
);

  typedef enum logic [1:0] {ST_PAUSED, ST_STEP, ST_RUN, ST_HALTED} state_t;

  logic [SyncLen-1:0]      r_run_sync;
  logic [SyncLen-1:0]      r_step_sync;
  logic                    r_step_d;
  logic                    w_run_s;
  logic                    w_step_s;
  logic                    w_stp;
  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [31:0]             r_run_div;
  logic [31:0]             w_run_div_nxt;
  logic                    r_cpu_en;
  logic                    w_cpu_en_nxt;
  logic [4:0]              r_rf_req;
  logic [`DM_ADDR_BIT-1:0] r_dm_addr;
  logic [31:0]             r_view;
  logic [31:0]             w_view_nxt;
  logic [31:0]             r_scan_div;
  logic [2:0]              r_idx;
  logic [2:0]              w_idx_nxt;
  logic                    w_tick;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run_sync  <= '0;
      r_step_sync <= '0;
      r_step_d    <= 1'b0;
    end else begin
      r_run_sync  <= {r_run_sync[SyncLen-2:0], i_run_sw};
      r_step_sync <= {r_step_sync[SyncLen-2:0], i_step_btn};
      r_step_d    <= w_step_s;
    end
  end

  assign w_run_s  = r_run_sync[SyncLen-1];
  assign w_step_s = r_step_sync[SyncLen-1];
  assign w_stp    = w_step_s & ~r_step_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_PAUSED;
      r_run_div <= 32'd0;
      r_cpu_en  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_run_div <= w_run_div_nxt;
      r_cpu_en  <= w_cpu_en_nxt;
    end
  end

  // cpu_en is computed for the next state so the flop lines up with STEP/RUN cycles
  always_comb begin
    w_state_nxt   = r_state;
    w_run_div_nxt = 32'd0;
    w_cpu_en_nxt  = 1'b0;
    case (r_state)
      ST_PAUSED: begin
        if (w_run_s)    w_state_nxt = ST_RUN;
        else if (w_stp) w_state_nxt = ST_STEP;
      end
      ST_STEP:   w_state_nxt = ST_PAUSED;
      ST_RUN:    if (!w_run_s) w_state_nxt = ST_PAUSED;
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_PAUSED;
    endcase
    if (dbg.halted) w_state_nxt = ST_HALTED;
    if (w_state_nxt == ST_RUN && r_state == ST_RUN)
      w_run_div_nxt = (r_run_div == RunDiv - 1) ? 32'd0 : r_run_div + 32'd1;
    w_cpu_en_nxt = (w_state_nxt == ST_STEP) ||
                   (w_state_nxt == ST_RUN && w_run_div_nxt == RunDiv - 1);
  end

  assign dbg.cpu_en = r_cpu_en;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rf_req  <= 5'd0;
      r_dm_addr <= '0;
    end else begin
      r_rf_req  <= i_addr_sw[4:0];
      r_dm_addr <= i_addr_sw;
    end
  end

  assign dbg.regfile_req_dbg  = r_rf_req;
  assign dbg.datamem_addr_dbg = r_dm_addr;

`ifdef DBG_STATS_EN
  logic [31:0] r_cyc_cnt;
  logic [31:0] r_jmp_cnt;
  logic [31:0] r_br_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_cnt_en;

  assign w_cnt_en = r_cpu_en & ~dbg.halted;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cyc_cnt   <= 32'd0;
      r_jmp_cnt   <= 32'd0;
      r_br_cnt    <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else if (w_cnt_en) begin
      r_cyc_cnt <= r_cyc_cnt + 32'd1;
      if (dbg.jumped)   r_jmp_cnt   <= r_jmp_cnt + 32'd1;
      if (dbg.branched) r_br_cnt    <= r_br_cnt + 32'd1;
      if (dbg.bubble)   r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end
`else
  logic w_unused_stats;
  assign w_unused_stats = dbg.jumped ^ dbg.branched ^ dbg.bubble;
`endif

  always_comb begin
    w_view_nxt = 32'h0;
    case (i_view_sel)
      3'd0: w_view_nxt = dbg.display;
      3'd1: w_view_nxt = dbg.pc_dbg;
      3'd2: w_view_nxt = dbg.regfile_data_dbg;
      3'd3: w_view_nxt = dbg.datamem_data_dbg;
`ifdef DBG_STATS_EN
      3'd4: w_view_nxt = r_cyc_cnt;
      3'd5: w_view_nxt = r_jmp_cnt;
      3'd6: w_view_nxt = r_br_cnt;
      3'd7: w_view_nxt = r_stall_cnt;
`endif
      default: w_view_nxt = 32'h0;
    endcase
  end

  // segments gfedcba active-high, inverted on the way out with dp held off
  function automatic logic [7:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;  4'h1: seg = 7'h06;  4'h2: seg = 7'h5B;  4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;  4'h5: seg = 7'h6D;  4'h6: seg = 7'h7D;  4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;  4'h9: seg = 7'h6F;  4'hA: seg = 7'h77;  4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;  4'hD: seg = 7'h5E;  4'hE: seg = 7'h79;  default: seg = 7'h71;
    endcase
    return {1'b1, ~seg};
  endfunction

  assign w_tick    = (r_scan_div == ScanDiv - 1);
  assign w_idx_nxt = r_idx + 3'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_view     <= 32'h0;
      r_scan_div <= 32'd0;
      r_idx      <= 3'd0;
      o_seg_sel  <= 8'hFF;
      o_seg_out  <= 8'hFF;
    end else begin
      r_view <= w_view_nxt;
      if (w_tick) begin
        r_scan_div <= 32'd0;
        r_idx      <= w_idx_nxt;
        o_seg_sel  <= ~(8'd1 << w_idx_nxt);
        o_seg_out  <= hex7(r_view[{w_idx_nxt, 2'b00} +: 4]);
      end else begin
        r_scan_div <= r_scan_div + 32'd1;
        o_seg_out  <= hex7(r_view[{r_idx, 2'b00} +: 4]);
      end
    end
  end

endmodule

// File: tb/tb_syn_debug_console.sv
// Scoreboard bench for syn_debug_console: expected cpu_en pulse cycles and display
// digits are queued by the stimulus and checked by independent monitors.
`ifndef DM_ADDR_BIT
`define DM_ADDR_BIT 10
`endif

module tb_syn_debug_console;
  localparam int RUN_DIV  = 4;
  localparam int SCAN_DIV = 4;
  localparam int AW       = `DM_ADDR_BIT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run_sw = 1'b0;
  logic          step_btn = 1'b0;
  logic [AW-1:0] addr_sw = '0;
  logic [2:0]    view_sel = 3'd0;
  logic [7:0]    seg_sel;
  logic [7:0]    seg_out;

  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          scan_base = 0;
  int          exp_pulse[$];
  logic [31:0] exp_seg[$];
  bit          seg_arm = 1'b0;
  logic [7:0]  prev_sel = 8'hFF;

  syn_debug_console_if dbg_if();

  syn_debug_console #(.RunDiv(RUN_DIV), .ScanDiv(SCAN_DIV), .SyncLen(2)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_run_sw   (run_sw),
    .i_step_btn (step_btn),
    .i_addr_sw  (addr_sw),
    .i_view_sel (view_sel),
    .o_seg_sel  (seg_sel),
    .o_seg_out  (seg_out),
    .dbg        (dbg_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // returns 1 ns after posedge number n (always at least one edge)
  task automatic go(input int n);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < n);
  endtask

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  always @(negedge clk) begin
    if (dbg_if.cpu_en !== 1'b0) begin
      if (exp_pulse.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL cpu_en unexpected pulse: got pulse at cycle %0d expected none", cyc);
      end else begin
        chk("cpu_en pulse cycle", cyc, exp_pulse.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (seg_arm && seg_sel !== prev_sel) begin
      if (exp_seg.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL seg unexpected tick: got sel %0h out %0h expected none", seg_sel, seg_out);
      end else begin
        chk("seg {sel,out}", {16'h0, seg_sel, seg_out}, exp_seg.pop_front());
      end
    end
    prev_sel = seg_sel;
  end

  // one full rotation of 8 digit ticks, starting at the next tick after the current one
  task automatic scan_check(input string nm, input logic [31:0] w);
    int m;
    int i;
    logic [7:0] s;
    m = (cyc - scan_base) / SCAN_DIV + 1;
    go(scan_base + SCAN_DIV * m);
    @(negedge clk);
    #1;
    seg_arm = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      i = (m + k) % 8;
      s = ~(8'd1 << i);
      exp_seg.push_back({16'h0, s, hex7(w[4*i +: 4])});
    end
    go(scan_base + SCAN_DIV * (m + 8));
    @(negedge clk);
    #1;
    seg_arm = 1'b0;
    while (exp_seg.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s missing tick: got none expected %0h", nm, exp_seg.pop_front());
    end
  endtask

  initial begin
    int t;
    int p;
    logic [31:0] e_cyc, e_jmp, e_br, e_stall;
    dbg_if.pc_dbg           = 32'h0;
    dbg_if.regfile_data_dbg = 32'h0;
    dbg_if.datamem_data_dbg = 32'h0;
    dbg_if.display          = 32'h0;
    dbg_if.halted           = 1'b0;
    dbg_if.jumped           = 1'b0;
    dbg_if.branched         = 1'b0;
    dbg_if.bubble           = 1'b0;

    go(3);
    chk("reset cpu_en", {31'h0, dbg_if.cpu_en}, 32'h0);
    chk("reset seg_sel", {24'h0, seg_sel}, 32'hFF);
    chk("reset seg_out", {24'h0, seg_out}, 32'hFF);
    chk("reset dm addr", 32'(dbg_if.datamem_addr_dbg), 32'h0);
    chk("reset rf req", {27'h0, dbg_if.regfile_req_dbg}, 32'h0);
    rst_n = 1'b1;
    scan_base = cyc;

    t = cyc + 3;
    go(t);
    addr_sw = AW'(10'h2B5);
    @(negedge clk);
    chk("dm addr before latency", 32'(dbg_if.datamem_addr_dbg), 32'h0);
    go(t + 1);
    chk("dm addr", 32'(dbg_if.datamem_addr_dbg), 32'h2B5);
    chk("rf req", {27'h0, dbg_if.regfile_req_dbg}, 32'h15);

    // run with a simultaneous step edge: run wins, 0001 cadence, no pulse past the drop
    t = cyc + 1;
    go(t);
    run_sw = 1'b1;
    step_btn = 1'b1;
    for (int k = 0; k < 4; k++) exp_pulse.push_back(t + 6 + 4 * k);
    go(t + 5);  step_btn = 1'b0;
    go(t + 12); step_btn = 1'b1;
    go(t + 15); step_btn = 1'b0;
    go(t + 19); run_sw = 1'b0;
    go(t + 30);

    // three single steps
    t = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      go(t + 10 * k);
      step_btn = 1'b1;
      exp_pulse.push_back(t + 10 * k + 3);
      go(t + 10 * k + 5);
      step_btn = 1'b0;
    end
    go(t + 30);

    // reset while running, asserted in a cycle where cpu_en is high
    t = cyc + 1;
    go(t);
    run_sw = 1'b1;
    exp_pulse.push_back(t + 6);
    go(t + 10);
    rst_n = 1'b0;
    #1;
    chk("async rst cpu_en", {31'h0, dbg_if.cpu_en}, 32'h0);
    chk("async rst seg_sel", {24'h0, seg_sel}, 32'hFF);
    chk("async rst seg_out", {24'h0, seg_out}, 32'hFF);
    chk("async rst dm addr", 32'(dbg_if.datamem_addr_dbg), 32'h0);
    chk("async rst rf req", {27'h0, dbg_if.regfile_req_dbg}, 32'h0);
    run_sw = 1'b0;
    go(t + 13);
    rst_n = 1'b1;
    scan_base = cyc;

    // 20 enabled cycles: jumped on 0-4, branched on 4/9/12, bubble on 10/11
    t = cyc + 1;
    go(t);
    run_sw = 1'b1;
    for (int i = 0; i < 20; i++) exp_pulse.push_back(t + 6 + 4 * i);
    for (int i = 0; i < 20; i++) begin
      p = t + 6 + 4 * i;
      if (i == 19) begin
        go(t + 81);
        run_sw = 1'b0;
      end
      go(p);
      dbg_if.jumped   = (i < 5);
      dbg_if.branched = (i == 4 || i == 9 || i == 12);
      dbg_if.bubble   = (i == 10 || i == 11);
      go(p + 1);
      dbg_if.jumped   = 1'b0;
      dbg_if.branched = 1'b0;
      dbg_if.bubble   = (i == 15);
      if (i == 15) begin
        go(p + 2);
        dbg_if.bubble = 1'b0;
      end
    end
    go(t + 95);

    dbg_if.pc_dbg           = 32'h00400C3A;
    dbg_if.display          = 32'h89ABCDEF;
    dbg_if.regfile_data_dbg = 32'h76543210;
    view_sel = 3'd1;
    scan_check("view pc", 32'h00400C3A);
    view_sel = 3'd0;
    scan_check("view display", 32'h89ABCDEF);
    view_sel = 3'd2;
    scan_check("view regfile", 32'h76543210);
`ifdef DBG_STATS_EN
    e_cyc = 32'd20; e_jmp = 32'd5; e_br = 32'd3; e_stall = 32'd2;
`else
    e_cyc = 32'd0;  e_jmp = 32'd0; e_br = 32'd0; e_stall = 32'd0;
`endif
    view_sel = 3'd4; scan_check("view cyc_cnt", e_cyc);
    view_sel = 3'd5; scan_check("view jmp_cnt", e_jmp);
    view_sel = 3'd6; scan_check("view br_cnt", e_br);
    view_sel = 3'd7; scan_check("view stall_cnt", e_stall);

    // halt arrives in the same cycle as a step edge, then run is requested
    t = cyc + 1;
    go(t);
    step_btn = 1'b1;
    go(t + 2); dbg_if.halted = 1'b1;
    go(t + 3); dbg_if.halted = 1'b0;
    go(t + 5); step_btn = 1'b0;
    go(t + 6); run_sw = 1'b1;
    go(t + 30);

    while (exp_pulse.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL cpu_en missing pulse: got none expected cycle %0d", exp_pulse.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
